// File: rtl/fpu_pkg.sv
// Shared floating-point constants and the fdiv control state encoding.
package fpu_pkg;

    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_MAX  = 255;
    localparam int unsigned MANT_W   = 23;
    // Quotient width: hidden bit, 23 fraction bits and one guard bit for M1 >= M2.
    localparam int unsigned QUOT_W   = MANT_W + 2;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } fdiv_state_e;

endpackage

// File: rtl/fdiv_step.sv
// One restoring-division step: conditional subtract of the divisor, then shift the remainder left.
module fdiv_step
    import fpu_pkg::*;
(
    input  logic [QUOT_W-1:0] rem_i,
    input  logic [MANT_W:0]   div_i,
    output logic [QUOT_W-1:0] rem_o,
    output logic              q_o
);

    logic [QUOT_W-1:0] diff;

    always_comb begin
        q_o   = (rem_i >= {1'b0, div_i});
        diff  = q_o ? (rem_i - {1'b0, div_i}) : rem_i;
        // diff < divisor < 2^24, so the shift never loses a set bit.
        rem_o = diff << 1;
    end

endmodule

// File: rtl/fdiv.sv
// Iterative truncating single-precision divider, BITS_PER_CYCLE quotient bits per CALC cycle.
// Define FDIV_DZ_EN to add the divide-by-zero output dz.
module fdiv
    import fpu_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        ovf,
    output logic        out_valid,
    input  logic        out_ready
`ifdef FDIV_DZ_EN
    ,
    output logic        dz
`endif
);

    localparam int unsigned N = QUOT_W / BITS_PER_CYCLE;

    fdiv_state_e       state_q;
    logic              s_q;
    logic [7:0]        e1_q;
    logic [7:0]        e2_q;
    logic [MANT_W:0]   m2_q;
    logic [QUOT_W-1:0] rem_q;
    logic [QUOT_W-1:0] quo_q;
    logic [QUOT_W-1:0] quo_d;
    logic [4:0]        cnt_q;
    logic [31:0]       y_q;
    logic              ovf_q;
    logic [31:0]       res_y;
    logic              res_ovf;
    logic [9:0]        e_res;
    logic [MANT_W-1:0] mant;

    logic [QUOT_W-1:0]         rem_c [BITS_PER_CYCLE+1];
    logic [BITS_PER_CYCLE-1:0] q_bits;

    assign rem_c[0] = rem_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        fdiv_step u_step (
            .rem_i (rem_c[i]),
            .div_i (m2_q),
            .rem_o (rem_c[i+1]),
            .q_o   (q_bits[BITS_PER_CYCLE-1-i])
        );
    end

    assign quo_d = {quo_q[QUOT_W-1-BITS_PER_CYCLE:0], q_bits};

    // Result is formed from quo_d so the final CALC edge can register it directly.
    always_comb begin
        mant    = quo_d[QUOT_W-1] ? quo_d[MANT_W:1] : quo_d[MANT_W-1:0];
        e_res   = {2'b00, e1_q} - {2'b00, e2_q}
                + (quo_d[QUOT_W-1] ? 10'(EXP_BIAS) : 10'(EXP_BIAS - 1));
        res_ovf = 1'b0;
        if (e2_q == 8'd0) begin
            res_y = {s_q, 8'(EXP_MAX), {MANT_W{1'b0}}};
        end else if (e1_q == 8'd0) begin
            res_y = {s_q, 31'b0};
        end else if (e1_q == 8'(EXP_MAX)) begin
            res_y = {s_q, 8'(EXP_MAX), {MANT_W{1'b0}}};
        end else if (e2_q == 8'(EXP_MAX)) begin
            res_y = {s_q, 31'b0};
        end else if (!e_res[9] && (e_res >= 10'(EXP_MAX))) begin
            res_y   = {s_q, 8'(EXP_MAX), {MANT_W{1'b0}}};
            res_ovf = 1'b1;
        end else if (e_res[9] || (e_res == 10'd0)) begin
            res_y = {s_q, 31'b0};
        end else begin
            res_y = {s_q, e_res[7:0], mant};
        end
    end

`ifdef FDIV_DZ_EN
    logic dz_q;
    logic res_dz;
    assign res_dz = (e2_q == 8'd0) && (e1_q != 8'd0);
    assign dz     = dz_q;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            s_q     <= 1'b0;
            e1_q    <= '0;
            e2_q    <= '0;
            m2_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
`ifdef FDIV_DZ_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        state_q <= StCalc;
                        s_q     <= x1[31] ^ x2[31];
                        e1_q    <= x1[30:23];
                        e2_q    <= x2[30:23];
                        m2_q    <= {1'b1, x2[MANT_W-1:0]};
                        rem_q   <= {2'b01, x1[MANT_W-1:0]};
                        quo_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                StCalc: begin
                    rem_q <= rem_c[BITS_PER_CYCLE];
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(N - 1)) begin
                        state_q <= StDone;
                        y_q     <= res_y;
                        ovf_q   <= res_ovf;
`ifdef FDIV_DZ_EN
                        dz_q    <= res_dz;
`endif
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign y         = y_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fdiv.sv
// Directed-vector bench for fdiv: runs BITS_PER_CYCLE = 1 and 5 instances side by side.
module tb_fdiv;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        ovf;
        logic        dz;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] x1, x2;
    logic        in_valid, out_ready;
    logic        in_ready1, out_valid1, ovf1;
    logic        in_ready5, out_valid5, ovf5;
    logic [31:0] y1, y5;
`ifdef FDIV_DZ_EN
    logic        dz1, dz5;
`endif

    int checks = 0;
    int errors = 0;

    vec_t vecs [17];

    always #5 clk = ~clk;

    fdiv #(.BITS_PER_CYCLE(1)) u_dut1 (
        .clk       (clk),
        .rstn      (rstn),
        .x1        (x1),
        .x2        (x2),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .y         (y1),
        .ovf       (ovf1),
        .out_valid (out_valid1),
        .out_ready (out_ready)
`ifdef FDIV_DZ_EN
        ,
        .dz        (dz1)
`endif
    );

    fdiv #(.BITS_PER_CYCLE(5)) u_dut5 (
        .clk       (clk),
        .rstn      (rstn),
        .x1        (x1),
        .x2        (x2),
        .in_valid  (in_valid),
        .in_ready  (in_ready5),
        .y         (y5),
        .ovf       (ovf5),
        .out_valid (out_valid5),
        .out_ready (out_ready)
`ifdef FDIV_DZ_EN
        ,
        .dz        (dz5)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input vec_t v, input int idx);
        logic lat_ok;
        x1        = v.a;
        x2        = v.b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check($sformatf("v%0d busy", idx), {30'b0, in_ready1, in_ready5}, 32'd0);
        lat_ok = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (out_valid1 !== (k >= 25)) lat_ok = 1'b0;
            if (out_valid5 !== (k >= 5)) lat_ok = 1'b0;
        end
        check($sformatf("v%0d latency", idx), {31'b0, lat_ok}, 32'd1);
        check($sformatf("v%0d y bpc1", idx), y1, v.y);
        check($sformatf("v%0d ovf bpc1", idx), {31'b0, ovf1}, {31'b0, v.ovf});
        check($sformatf("v%0d y bpc5", idx), y5, v.y);
        check($sformatf("v%0d ovf bpc5", idx), {31'b0, ovf5}, {31'b0, v.ovf});
`ifdef FDIV_DZ_EN
        check($sformatf("v%0d dz", idx), {30'b0, dz1, dz5}, {30'b0, v.dz, v.dz});
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check($sformatf("v%0d idle", idx),
              {28'b0, in_ready1, in_ready5, out_valid1, out_valid5}, 32'b1100);
    endtask

    initial begin
        logic hold_ok;
        logic quiet;
        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0}; // 6/2
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0}; // 1/3 truncated
        vecs[2]  = '{32'hC0A00000, 32'h00000000, 32'hFF800000, 1'b0, 1'b1}; // -5/0
        vecs[3]  = '{32'h7F000000, 32'h00800001, 32'h7F800000, 1'b1, 1'b0}; // overflow
        vecs[4]  = '{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 1'b0}; // underflow
        vecs[5]  = '{32'h3F800000, 32'hC0000000, 32'hBF000000, 1'b0, 1'b0}; // 1/-2
        vecs[6]  = '{32'h00000000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0}; // 0/0
        vecs[7]  = '{32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 1'b0}; // -0/2
        vecs[8]  = '{32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, 1'b0}; // inf/2
        vecs[9]  = '{32'h40000000, 32'hFF800000, 32'h80000000, 1'b0, 1'b0}; // 2/-inf
        vecs[10] = '{32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b1, 1'b0}; // E = 255
        vecs[11] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 1'b0}; // E = 254
        vecs[12] = '{32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 1'b0}; // E = 1
        vecs[13] = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0}; // E = 0
        vecs[14] = '{32'h00400000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0}; // denormal / 1
        vecs[15] = '{32'h3F800000, 32'h00400000, 32'h7F800000, 1'b0, 1'b1}; // 1 / denormal
        vecs[16] = '{32'h3FC00000, 32'h3FA00000, 32'h3F999999, 1'b0, 1'b0}; // 1.5/1.25

        rstn      = 1'b0;
        x1        = '0;
        x2        = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #12;
        check("reset y", y1 | y5, 32'd0);
        check("reset flags", {28'b0, in_ready1, in_ready5, out_valid1 | ovf1, out_valid5 | ovf5},
              32'b1100);
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) run_op(vecs[i], i);

        // Backpressure: hold result for 10 cycles while a new request is offered.
        x1       = 32'h40C00000;
        x2       = 32'h40000000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 25; k++) tick();
        x1       = 32'h3F800000;
        x2       = 32'h40400000;
        in_valid = 1'b1;
        hold_ok  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (y1 !== 32'h40400000 || y5 !== 32'h40400000) hold_ok = 1'b0;
            if (in_ready1 || in_ready5 || !out_valid1 || !out_valid5) hold_ok = 1'b0;
        end
        check("bp hold", {31'b0, hold_ok}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp release", {28'b0, in_ready1, in_ready5, out_valid1, out_valid5}, 32'b1100);
        in_valid = 1'b0;
        tick();
        check("bp no accept", {30'b0, in_ready1, in_ready5}, 32'b11);

        // Reset pulse mid-CALC aborts the operation.
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        rstn = 1'b0;
        #2;
        check("mid rst y", y1 | y5, 32'd0);
        check("mid rst flags", {28'b0, in_ready1, in_ready5, out_valid1 | ovf1, out_valid5 | ovf5},
              32'b1100);
        #2;
        rstn  = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (out_valid1 || out_valid5) quiet = 1'b0;
        end
        check("abort silent", {31'b0, quiet}, 32'd1);
        run_op(vecs[0], 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
